ethtransmit: RTL
================

// Module: ethtransmit
// PURPOSE
//  Ethernet frame transmitter for the RTL8211EG GMII path; TX counterpart of ethreceive.
//  Reads a frame from the 16-bit TX buffer memory and drives the PHY byte-wide:
//  7x 0x55 preamble, 0xD5 SFD, data, zero pad to minimum length, 4-byte FCS, then IPG.
//  CRC is computed by the shared external CRC unit, controlled through crcen/crcre.
// PARAMETERS
//  MINLEN   60    minimum frame bytes before FCS; shorter frames are zero-padded
//  MAXLEN   1514  maximum accepted byte count (excluding FCS)
//  IPG      12    idle byte times after FCS before txrdy asserts
// PORTS
//  clk      in   1   clock; all state changes on the falling edge (negedge clk)
//  clr      in   1   reset, asynchronous, active-high
//  txreq    in   1   level request to send the frame held in the buffer
//  txcntb   in   11  frame byte count excluding FCS, sampled in IDLE when txreq=1
//  txbdata  in   16  buffer read data; byte order {first[15:8], second[7:0]}
//  crc      in   32  finalized FCS from CRC unit, transmitted crc[7:0] first
//  txdone   in   1   host acknowledge of txrdy
//  txbaddr  out  10  buffer word address (registered)
//  dataout  out  8   byte to PHY TXD
//  txen     out  1   PHY TX_EN
//  txer     out  1   PHY TX_ER (held 0; reserved)
//  crcen    out  1   CRC calculation enable
//  crcre    out  1   CRC reset
//  txrdy    out  1   frame finished, held until txdone
//  err_gen  out  1   length error on last request
// BEHAVIOUR
//  Reset (async): state=IDLE, txen=0, txer=0, dataout=0, txbaddr=0, crcen=0, crcre=1,
//   txrdy=0, err_gen=0. clr mid-frame drops txen immediately; no partial FCS is sent.
//  Buffer read latency: txbdata valid one edge after txbaddr changes.
//  IDLE: crcen=0, crcre=1, txbaddr=0, txen=0. On txreq=1: latch len=txcntb, clear err_gen;
//   len==0 or len>MAXLEN -> err_gen=1, go FINISH (no txen); else go PREAMBLE.
//  PREAMBLE: 7 edges, dataout=0x55, txen=1; word 0 prefetched. Then SFD.
//  SFD: 1 edge, dataout=0xD5, txen=1; crcre=0. Then DATA.
//  DATA: one byte per edge, crcen=1; byte k = high byte of word k/2 when k even,
//   low byte when odd. On the edge emitting a high byte, the word is latched and
//   txbaddr increments. After byte len-1: len<MINLEN -> PAD, else CRC.
//  PAD: dataout=0x00, crcen=1, until total bytes = MINLEN. Then CRC.
//  CRC: crcen=0 on entry (crc input then stable); 4 edges emit crc[7:0],[15:8],[23:16],[31:24].
//  IPG: txen=0, dataout=0 for IPG edges. Then FINISH.
//  FINISH: txrdy=1 until txdone=1; then txrdy=0, go IDLE. txreq ignored outside IDLE.
//  Odd len: low byte of last word discarded. Byte counter 11 bits, no wrap (len<=MAXLEN).
//  Simultaneous txdone with txrdy rise: txrdy still asserts one edge before clearing.
//  Latency: txreq seen at edge N -> first 0x55 at edge N+1; txen high for 8+max(len,MINLEN)+4 edges.
// TESTING
//  len=64, buffer ramp 0x0001,0x0203.. -> 55x7,D5,00,01,02,03..3F, 4 FCS bytes; txen 76 edges.
//  len=42 -> 42 data bytes + 18 bytes 0x00 pad, FCS over 60 bytes; crcen high 60 edges.
//  len=61 (odd) -> 61 data bytes, byte 61 is high byte of word 30; txbaddr peaks at 31.
//  len=0 and len=1515 -> err_gen=1, txen never asserts, txrdy=1 until txdone.
//  clr pulse during DATA byte 20 -> txen=0 at once, txbaddr=0; next txreq sends full frame.
//  Known frame with reference FCS -> dataout FCS bytes match; txrdy asserts after 12 IPG edges.

Source files
------------

// File: rtl/ethtransmit_if.sv
// Signal bundle between the GMII frame transmitter and its host/buffer side.
// The transmitter takes the slave modport; the host/buffer/CRC side takes master.
interface ethtransmit_if;
  logic        txreq;
  logic [10:0] txcntb;
  logic [15:0] txbdata;
  logic [31:0] crc;
  logic        txdone;
  logic [9:0]  txbaddr;
  logic [7:0]  dataout;
  logic        txen;
  logic        txer;
  logic        crcen;
  logic        crcre;
  logic        txrdy;
  logic        err_gen;

  modport master (
    output txreq, txcntb, txbdata, crc, txdone,
    input  txbaddr, dataout, txen, txer, crcen, crcre, txrdy, err_gen
  );

  modport slave (
    input  txreq, txcntb, txbdata, crc, txdone,
    output txbaddr, dataout, txen, txer, crcen, crcre, txrdy, err_gen
  );
endinterface

// File: rtl/ethtransmit.sv
// GMII Ethernet frame transmitter: preamble, SFD, buffered data, zero pad, external FCS, IPG.
// All state advances on the falling clock edge; clr is an asynchronous active-high reset.
module ethtransmit #(
  parameter int unsigned MINLEN = 60,
  parameter int unsigned MAXLEN = 1514,
  parameter int unsigned IPG    = 12
) (
  input logic          clk,
  input logic          clr,
  ethtransmit_if.slave io_tx
);

  localparam logic [10:0] LP_MAXLEN    = 11'(MAXLEN);
  localparam logic [10:0] LP_MINLEN    = 11'(MINLEN);
  localparam logic [10:0] LP_MINLEN_M1 = 11'(MINLEN - 1);
  localparam logic [7:0]  LP_IPG_M1    = 8'(IPG - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StCrc,
    StIpg,
    StFinish
  } state_e;

  state_e      r_state;
  logic [10:0] r_len;
  logic [10:0] r_cnt;
  logic [7:0]  r_seq;
  logic [7:0]  r_lo;
  logic [9:0]  r_txbaddr;
  logic [7:0]  r_dataout;
  logic        r_txen;
  logic        r_crcen;
  logic        r_crcre;
  logic        r_txrdy;
  logic        r_err;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= StIdle;
      r_len     <= '0;
      r_cnt     <= '0;
      r_seq     <= '0;
      r_lo      <= '0;
      r_txbaddr <= '0;
      r_dataout <= '0;
      r_txen    <= 1'b0;
      r_crcen   <= 1'b0;
      r_crcre   <= 1'b1;
      r_txrdy   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_txen    <= 1'b0;
          r_dataout <= '0;
          r_crcen   <= 1'b0;
          r_crcre   <= 1'b1;
          r_txbaddr <= '0;
          r_cnt     <= '0;
          r_seq     <= '0;
          if (io_tx.txreq) begin
            r_len <= io_tx.txcntb;
            r_err <= 1'b0;
            if (io_tx.txcntb == 11'd0 || io_tx.txcntb > LP_MAXLEN) begin
              r_err   <= 1'b1;
              r_txrdy <= 1'b1;
              r_state <= StFinish;
            end else begin
              r_state <= StPreamble;
            end
          end
        end

        StPreamble: begin
          r_dataout <= 8'h55;
          r_txen    <= 1'b1;
          r_seq     <= r_seq + 8'd1;
          if (r_seq == 8'd6) begin
            r_seq   <= '0;
            r_state <= StSfd;
          end
        end

        StSfd: begin
          r_dataout <= 8'hD5;
          r_txen    <= 1'b1;
          r_crcre   <= 1'b0;
          r_state   <= StData;
        end

        // Even bytes come from the freshly fetched word; its low half is held for the odd byte.
        StData: begin
          r_crcen <= 1'b1;
          if (!r_cnt[0]) begin
            r_dataout <= io_tx.txbdata[15:8];
            r_lo      <= io_tx.txbdata[7:0];
            r_txbaddr <= r_txbaddr + 10'd1;
          end else begin
            r_dataout <= r_lo;
          end
          r_cnt <= r_cnt + 11'd1;
          if (r_cnt == r_len - 11'd1) begin
            r_state <= (r_len < LP_MINLEN) ? StPad : StCrc;
          end
        end

        StPad: begin
          r_dataout <= '0;
          r_crcen   <= 1'b1;
          r_cnt     <= r_cnt + 11'd1;
          if (r_cnt == LP_MINLEN_M1) begin
            r_state <= StCrc;
          end
        end

        // crcen drops on the first FCS edge so the CRC unit result holds still.
        StCrc: begin
          r_crcen <= 1'b0;
          case (r_seq[1:0])
            2'd0:    r_dataout <= io_tx.crc[7:0];
            2'd1:    r_dataout <= io_tx.crc[15:8];
            2'd2:    r_dataout <= io_tx.crc[23:16];
            default: r_dataout <= io_tx.crc[31:24];
          endcase
          r_seq <= r_seq + 8'd1;
          if (r_seq == 8'd3) begin
            r_seq   <= '0;
            r_state <= StIpg;
          end
        end

        StIpg: begin
          r_txen    <= 1'b0;
          r_dataout <= '0;
          r_seq     <= r_seq + 8'd1;
          if (r_seq == LP_IPG_M1) begin
            r_seq   <= '0;
            r_txrdy <= 1'b1;
            r_state <= StFinish;
          end
        end

        StFinish: begin
          if (io_tx.txdone) begin
            r_txrdy   <= 1'b0;
            r_crcre   <= 1'b1;
            r_txbaddr <= '0;
            r_state   <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_tx.txbaddr = r_txbaddr;
  assign io_tx.dataout = r_dataout;
  assign io_tx.txen    = r_txen;
  assign io_tx.txer    = 1'b0;
  assign io_tx.crcen   = r_crcen;
  assign io_tx.crcre   = r_crcre;
  assign io_tx.txrdy   = r_txrdy;
  assign io_tx.err_gen = r_err;

endmodule
